// File: rtl/trigger_capture_pkg.sv
// Shared encodings and modular address helpers for the triggered capture buffer.
package trigger_capture_pkg;

  localparam logic [1:0] MODE_AUTO   = 2'd0;
  localparam logic [1:0] MODE_NORMAL = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;

  typedef logic [2:0] state_t;

  localparam state_t ST_PRE  = 3'd0;
  localparam state_t ST_WAIT = 3'd1;
  localparam state_t ST_POST = 3'd2;
  localparam state_t ST_DONE = 3'd3;
  localparam state_t ST_IDLE = 3'd4;

  // Both operands must already lie in [0, depth).
  function automatic int wrap_add(input int a, input int b, input int depth);
    int s;
    s = a + b;
    return (s >= depth) ? s - depth : s;
  endfunction

  function automatic int wrap_sub(input int a, input int b, input int depth);
    return (a >= b) ? a - b : a + depth - b;
  endfunction

endpackage

// File: rtl/trigger_capture_ram.sv
// Two-bank sample store: one write port into the back bank, one registered
// read port on the front bank that returns zero when the read is masked.
module capture_ram #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 640,
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic              wr_bank_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic              rd_bank_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] bank0_mem [DEPTH];
  logic [DATA_W-1:0] bank1_mem [DEPTH];
  logic [DATA_W-1:0] rd_q;

  // NOTE: the arrays get no reset term; adding one prevents block RAM inference.
  always_ff @(posedge clock) begin
    if (wr_en_i && !wr_bank_i) bank0_mem[wr_addr_i] <= wr_data_i;
    if (wr_en_i &&  wr_bank_i) bank1_mem[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q <= '0;
    end else if (rd_en_i) begin
      rd_q <= rd_bank_i ? bank1_mem[rd_addr_i] : bank0_mem[rd_addr_i];
    end else begin
      rd_q <= '0;
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/trigger_capture.sv
// Triggered acquisition of one screen-width record around a level crossing,
// double-buffered so the display bank only changes at frame boundaries.
module trigger_capture
  import trigger_capture_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int DEPTH   = 640,
  parameter int ADDR_W  = 10,
  parameter int X_W     = 11,
  parameter int PRETRIG = 64,
  parameter int AUTO_TO = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [1:0]        trig_mode,
  input  logic              arm,
  input  logic              frame_sync,
  input  logic [X_W-1:0]    rd_x,
  output logic [DATA_W-1:0] rd_data,
  output logic              triggered,
  output logic              capturing,
  output logic              front_valid
);

  localparam int CNT_MAX = (AUTO_TO > DEPTH) ? AUTO_TO : DEPTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  CNT_PRE  = CNT_W'(PRETRIG);
  localparam logic [CNT_W-1:0]  CNT_POST = CNT_W'(DEPTH - PRETRIG);
  localparam logic [CNT_W-1:0]  CNT_AUTO = CNT_W'(AUTO_TO);
  localparam logic [ADDR_W-1:0] WP_LAST  = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wp_q, wp_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                back_q, back_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic [ADDR_W-1:0]   front_start_q, front_start_d;
  logic                front_valid_q, front_valid_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                prev_ok_q, prev_ok_d;
  logic [1:0]          mode_q, mode_d;
  logic                triggered_q, triggered_d;

  logic                crossed;
  logic                hit;
  logic                auto_fire;
  logic [CNT_W-1:0]    cnt_inc;
  logic                wr_en;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;

  assign capturing = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);

  always_comb begin
    if (trig_slope) crossed = (prev_q > trig_level) && (sample_data <= trig_level);
    else            crossed = (prev_q < trig_level) && (sample_data >= trig_level);
  end

  assign hit       = prev_ok_q && crossed;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign auto_fire = (mode_q == MODE_AUTO) && (cnt_inc == CNT_AUTO);

  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    wp_d          = wp_q;
    cnt_d         = cnt_q;
    back_d        = back_q;
    start_d       = start_q;
    front_start_d = front_start_q;
    front_valid_d = front_valid_q;
    prev_d        = prev_q;
    prev_ok_d     = prev_ok_q;
    mode_d        = mode_q;
    triggered_d   = 1'b0;
    wr_en         = 1'b0;

    if (sample_valid && capturing) begin
      wr_en     = 1'b1;
      wp_d      = (wp_q == WP_LAST) ? '0 : wp_q + ADDR_W'(1);
      prev_d    = sample_data;
      prev_ok_d = 1'b1;
    end

    case (state_q)
      ST_PRE: begin
        if (sample_valid) begin
          if (cnt_inc == CNT_PRE) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
            mode_d  = trig_mode;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_WAIT: begin
        if (sample_valid) begin
          if (hit || auto_fire) begin
            // The record opens PRETRIG samples before the trigger sample's slot.
            start_d     = ADDR_W'(wrap_sub(int'(wp_q), PRETRIG, DEPTH));
            triggered_d = 1'b1;
            cnt_d       = CNT_W'(1);
            state_d     = ST_POST;
          end else if (mode_q == MODE_AUTO) begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_POST: begin
        if (sample_valid) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_POST) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (frame_sync) begin
          back_d        = ~back_q;
          front_start_d = start_q;
          front_valid_d = 1'b1;
          mode_d        = trig_mode;
          cnt_d         = '0;
          prev_ok_d     = 1'b0;
          state_d       = (trig_mode == MODE_SINGLE) ? ST_IDLE : ST_PRE;
        end
      end
      ST_IDLE: begin
        if (arm) begin
          state_d   = ST_PRE;
          cnt_d     = '0;
          prev_ok_d = 1'b0;
        end
      end
      default: state_d = ST_PRE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_PRE;
      wp_q          <= '0;
      cnt_q         <= '0;
      back_q        <= 1'b1;
      start_q       <= '0;
      front_start_q <= '0;
      front_valid_q <= 1'b0;
      prev_q        <= '0;
      prev_ok_q     <= 1'b0;
      mode_q        <= MODE_NORMAL;
      triggered_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wp_q          <= wp_d;
      cnt_q         <= cnt_d;
      back_q        <= back_d;
      start_q       <= start_d;
      front_start_q <= front_start_d;
      front_valid_q <= front_valid_d;
      prev_q        <= prev_d;
      prev_ok_q     <= prev_ok_d;
      mode_q        <= mode_d;
      triggered_q   <= triggered_d;
    end
  end

  // Out-of-range columns and an empty front bank both read back as zero.
  assign rd_en   = front_valid_q && (rd_x < X_W'(DEPTH));
  assign rd_addr = ADDR_W'(wrap_add(int'(front_start_q), int'(rd_x), DEPTH));

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock     (clock),
    .reset     (reset),
    .wr_en_i   (wr_en),
    .wr_bank_i (back_q),
    .wr_addr_i (wp_q),
    .wr_data_i (sample_data),
    .rd_en_i   (rd_en),
    .rd_bank_i (~back_q),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign triggered   = triggered_q;
  assign front_valid = front_valid_q;

endmodule

// File: tb/tb_trigger_capture.sv
// Directed and randomized checks of trigger_capture against a record-level
// model: find the trigger in the sample stream, slice the record around it.
module tb_trigger_capture;
  import trigger_capture_pkg::*;

  localparam int DATA_W  = 12;
  localparam int DEPTH   = 640;
  localparam int ADDR_W  = 10;
  localparam int X_W     = 11;
  localparam int PRETRIG = 64;
  localparam int AUTO_TO = 4096;

  logic              clock = 1'b0;
  logic              reset;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic [DATA_W-1:0] trig_level;
  logic              trig_slope;
  logic [1:0]        trig_mode;
  logic              arm;
  logic              frame_sync;
  logic [X_W-1:0]    rd_x;
  logic [DATA_W-1:0] rd_data;
  logic              triggered;
  logic              capturing;
  logic              front_valid;

  always #5 clock = ~clock;

  trigger_capture #(
    .DATA_W (DATA_W), .DEPTH (DEPTH), .ADDR_W (ADDR_W),
    .X_W (X_W), .PRETRIG (PRETRIG), .AUTO_TO (AUTO_TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .trig_level   (trig_level),
    .trig_slope   (trig_slope),
    .trig_mode    (trig_mode),
    .arm          (arm),
    .frame_sync   (frame_sync),
    .rd_x         (rd_x),
    .rd_data      (rd_data),
    .triggered    (triggered),
    .capturing    (capturing),
    .front_valid  (front_valid)
  );

  int total = 0;
  int bad = 0;
  int fed = 0;
  int trig_seen = 0;
  int trig_at = -1;

  logic [DATA_W-1:0] stim [$];
  logic [DATA_W-1:0] exp_rec [DEPTH];

  always @(negedge clock) begin
    if (triggered) begin
      trig_seen++;
      trig_at = fed;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic bit crosses(input logic [DATA_W-1:0] p, input logic [DATA_W-1:0] c,
                                 input logic [DATA_W-1:0] lvl, input bit falling);
    return falling ? (p > lvl && c <= lvl) : (p < lvl && c >= lvl);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic feed(input logic [DATA_W-1:0] s, input bit fs);
    sample_valid = 1'b1;
    sample_data  = s;
    frame_sync   = fs;
    @(posedge clock);
    fed++;
    @(negedge clock);
    sample_valid = 1'b0;
    frame_sync   = 1'b0;
    repeat ($urandom_range(0, 1)) @(negedge clock);
  endtask

  task automatic pulse_fs();
    frame_sync = 1'b1;
    @(negedge clock);
    frame_sync = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clock);
    arm = 1'b0;
  endtask

  task automatic read_chk(input int x, input logic [DATA_W-1:0] e, input string tag);
    rd_x = X_W'(x);
    @(negedge clock);
    check(tag, 32'(rd_data), 32'(e));
  endtask

  task automatic check_record(input string tag);
    for (int x = 0; x < DEPTH; x++) read_chk(x, exp_rec[x], tag);
  endtask

  // Locate the trigger in stim, derive the record, feed exactly the samples
  // the capture consumes, and confirm it stops on the last one.
  task automatic run_capture(input bit auto_mode, input bit fs_last, input string tag);
    int t;
    int n;
    t = -1;
    for (int i = PRETRIG; i < stim.size() && t < 0; i++) begin
      if (crosses(stim[i-1], stim[i], trig_level, trig_slope) ||
          (auto_mode && i == PRETRIG + AUTO_TO - 1))
        t = i;
    end
    if (t < 0 || stim.size() < t + DEPTH - PRETRIG) begin
      $display("FAIL %s: stimulus holds no complete record", tag);
      $fatal(1, "bench stimulus error");
    end
    n = t + DEPTH - PRETRIG;
    for (int k = 0; k < DEPTH; k++) exp_rec[k] = stim[t - PRETRIG + k];
    fed = 0;
    trig_seen = 0;
    trig_at = -1;
    for (int i = 0; i < n - 1; i++) feed(stim[i], 1'b0);
    check({tag, ".busy_before_last"}, 32'(capturing), 32'd1);
    feed(stim[n-1], fs_last);
    check({tag, ".done_after_last"}, 32'(capturing), 32'd0);
    check({tag, ".trig_count"}, 32'(trig_seen), 32'd1);
    check({tag, ".trig_index"}, 32'(trig_at), 32'(t + 1));
  endtask

  initial begin
    int v;
    reset = 1'b1; sample_valid = 1'b0; sample_data = '0; trig_level = '0;
    trig_slope = 1'b0; trig_mode = MODE_NORMAL; arm = 1'b0; frame_sync = 1'b0; rd_x = '0;
    do_reset();
    check("rst.capturing", 32'(capturing), 32'd1);
    check("rst.front_valid", 32'(front_valid), 32'd0);
    check("rst.triggered", 32'(triggered), 32'd0);
    check("rst.rd_data", 32'(rd_data), 32'd0);

    // Rising ramp, step 8, level 2048.
    trig_level = 12'd2048; trig_slope = 1'b0;
    stim.delete();
    for (int k = 0; k < 1000; k++) stim.push_back(DATA_W'((k * 8) % 4096));
    run_capture(1'b0, 1'b0, "t1");
    check("t1.front_valid_pre_swap", 32'(front_valid), 32'd0);
    pulse_fs();
    check("t1.front_valid", 32'(front_valid), 32'd1);
    read_chk(64, 12'd2048, "t1.x64");
    read_chk(63, 12'd2040, "t1.x63");
    check_record("t1.rec");

    // Falling descending ramp, level 1000.
    trig_level = 12'd1000; trig_slope = 1'b1;
    stim.delete();
    for (int k = 0; k < 1300; k++) begin
      v = 4000 - 5 * k;
      if (v < 0) v += 4096;
      stim.push_back(DATA_W'(v));
    end
    run_capture(1'b0, 1'b0, "t2");
    pulse_fs();
    read_chk(PRETRIG, 12'd1000, "t2.x_pretrig");
    check_record("t2.rec");

    // Normal mode, constant input below level: never triggers.
    trig_mode = MODE_NORMAL; trig_level = 12'd2048; trig_slope = 1'b0;
    do_reset();
    trig_seen = 0;
    for (int k = 0; k < 4800; k++) feed(12'd500, 1'b0);
    check("t3n.trig_count", 32'(trig_seen), 32'd0);
    check("t3n.capturing", 32'(capturing), 32'd1);
    pulse_fs();
    check("t3n.front_valid", 32'(front_valid), 32'd0);
    read_chk(10, 12'd0, "t3n.rd_masked");

    // Auto mode forces a trigger after AUTO_TO samples in WAIT.
    trig_mode = MODE_AUTO;
    do_reset();
    stim.delete();
    for (int k = 0; k < 4800; k++) stim.push_back(12'd500);
    run_capture(1'b1, 1'b0, "t3a");
    pulse_fs();
    check("t3a.front_valid", 32'(front_valid), 32'd1);
    check_record("t3a.rec");

    // Single mode: one capture, then IDLE until armed.
    trig_mode = MODE_SINGLE; trig_level = 12'd1500; trig_slope = 1'b0;
    stim.delete();
    for (int k = 0; k < 1200; k++) stim.push_back(DATA_W'((k * 3) % 4096));
    run_capture(1'b0, 1'b0, "t4a");
    pulse_fs();
    check_record("t4a.rec");
    trig_seen = 0;
    for (int k = 0; k < 200; k++) feed(DATA_W'((k * 16) % 4096), 1'b0);
    repeat (3) begin
      pulse_fs();
      repeat (4) @(negedge clock);
    end
    check("t4.idle_capturing", 32'(capturing), 32'd0);
    check("t4.idle_trig", 32'(trig_seen), 32'd0);
    check("t4.idle_front_valid", 32'(front_valid), 32'd1);
    read_chk(0, exp_rec[0], "t4.stable0");
    read_chk(100, exp_rec[100], "t4.stable100");
    read_chk(320, exp_rec[320], "t4.stable320");
    read_chk(639, exp_rec[639], "t4.stable639");
    pulse_arm();
    check("t4.armed_capturing", 32'(capturing), 32'd1);
    trig_level = 12'd777; trig_slope = 1'b1;
    stim.delete();
    for (int k = 0; k < 1500; k++) stim.push_back(DATA_W'($urandom_range(0, 4095)));
    run_capture(1'b0, 1'b0, "t4b");
    pulse_fs();
    check_record("t4b.rec");
    trig_seen = 0;
    for (int k = 0; k < 200; k++) feed(DATA_W'($urandom_range(0, 4095)), 1'b0);
    check("t4b.idle_capturing", 32'(capturing), 32'd0);
    check("t4b.idle_trig", 32'(trig_seen), 32'd0);

    // Completion coincident with frame_sync: swap waits for the next one.
    trig_mode = MODE_NORMAL; trig_slope = 1'b0;
    trig_level = DATA_W'($urandom_range(1000, 3000));
    do_reset();
    stim.delete();
    for (int k = 0; k < 1500; k++) stim.push_back(DATA_W'($urandom_range(0, 4095)));
    run_capture(1'b0, 1'b1, "t5");
    check("t5.no_swap", 32'(front_valid), 32'd0);
    read_chk(5, 12'd0, "t5.rd_before_swap");
    pulse_fs();
    check("t5.front_valid", 32'(front_valid), 32'd1);
    check_record("t5.rec");
    read_chk(700, 12'd0, "t5.x700");
    read_chk(2047, 12'd0, "t5.x2047");

    // Reset in the middle of POST, then a clean capture.
    trig_level = 12'd3000; trig_slope = 1'b0;
    trig_seen = 0;
    for (int k = 0; k < 700; k++) feed(DATA_W'((k * 5) % 4096), 1'b0);
    check("t6.in_post", 32'(capturing), 32'd1);
    check("t6.trig_seen", 32'(trig_seen), 32'd1);
    rd_x = 11'd10;
    reset = 1'b1;
    @(negedge clock);
    check("t6.rst_capturing", 32'(capturing), 32'd1);
    check("t6.rst_front_valid", 32'(front_valid), 32'd0);
    check("t6.rst_rd_data", 32'(rd_data), 32'd0);
    check("t6.rst_triggered", 32'(triggered), 32'd0);
    reset = 1'b0;
    trig_level = 12'd2500; trig_slope = 1'b1;
    stim.delete();
    for (int k = 0; k < 1500; k++) stim.push_back(DATA_W'($urandom_range(0, 4095)));
    run_capture(1'b0, 1'b0, "t6");
    pulse_fs();
    check("t6.front_valid", 32'(front_valid), 32'd1);
    check_record("t6.rec");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
